// File: rtl/game_sequencer.sv
// game_sequencer: start/serve/play/over game flow with frame ticks, widget enables and lives.
// Define SCORE_EN to add an 8-bit saturating hit score counter (score is 0 otherwise).
module game_sequencer #(
  parameter int FRAME_DIV    = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int LIVES        = 3,
  parameter int MISS_X       = 798
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic        startBtn,
  input  logic [10:0] ballRight,
  input  logic        hit,
  output logic        widgetEnable,
  output logic        widgetReset,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic        gameOver,
  output logic [7:0]  score
);
  localparam logic [1:0] IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3;
  logic [1:0] next;
  logic       tick, btn_prev, first;
  logic [3:0] div;
  logic [7:0] serve_cnt;
  logic       rise, start, miss, serve_done, wrap;
  assign rise       = startBtn & ~btn_prev;
  assign start      = rise && (state == IDLE || state == OVER);
  assign miss       = state == PLAY && tick && ballRight >= 11'(MISS_X);
  assign serve_done = state == SERVE && tick && serve_cnt == 8'(SERVE_FRAMES - 1);
  assign wrap       = div == 4'(FRAME_DIV - 1);

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? SERVE : IDLE;
      SERVE:   next = serve_done ? PLAY : SERVE;
      PLAY:    next = !miss ? PLAY : lives <= 2'd1 ? OVER : SERVE;
      default: next = start ? SERVE : OVER;
    endcase
  end

  always_comb begin
    widgetEnable = state == PLAY && tick && wrap;
    widgetReset  = state == IDLE || (state == SERVE && first);
    gameOver     = state == OVER;
  end

  // first marks the single cycle after entering SERVE, when widgets are re-reset
  always_ff @(posedge clk)
    if (reset) begin
      tick      <= 1'b0;
      btn_prev  <= 1'b0;
      first     <= 1'b0;
      div       <= '0;
      serve_cnt <= '0;
      lives     <= '0;
    end else begin
      tick      <= X == 11'd0 && Y == 11'd600;
      btn_prev  <= startBtn;
      first     <= next == SERVE && state != SERVE;
      div       <= state != PLAY ? 4'd0 : !tick ? div : wrap ? 4'd0 : div + 4'd1;
      serve_cnt <= state != SERVE ? 8'd0 : tick ? serve_cnt + 8'd1 : serve_cnt;
      lives     <= start ? 2'(LIVES) : (miss && lives != 2'd0) ? lives - 2'd1 : lives;
    end

`ifdef SCORE_EN
  always_ff @(posedge clk)
    if (reset || start) score <= '0;
    else if (state == PLAY && hit && !miss && score != 8'hff) score <= score + 8'd1;
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign score = '0;
`endif
endmodule
